// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit and the ALU control decoder:
// operation codes, FSM state encoding and the one-bit shift step.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_OR   = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_SLTU = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  // True for the multi-cycle shift operations.
  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Shift a value by exactly one bit in the direction/fill of op.
  function automatic logic [DATA_W-1:0] shift_one(input alu_op_e op,
                                                  input logic [DATA_W-1:0] v);
    case (op)
      ALU_SLL: return {v[DATA_W-2:0], 1'b0};
      ALU_SRL: return {1'b0, v[DATA_W-1:1]};
      ALU_SRA: return {v[DATA_W-1], v[DATA_W-1:1]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU operations. Shift codes are reported legal but produce 0;
// the execute unit computes shifts itself over several cycles.
module alu_comb
  import alu_pkg::*;
(
  input  alu_op_e            op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic [DATA_W-1:0]  y,
  output logic               legal
);

  // Decode the operation and compute its result; unknown codes give 0.
  always_comb begin
    y     = '0;
    legal = 1'b1;
    case (op)
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SRL, ALU_SRA: y = '0;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ops through alu_comb, shifts by a 1-bit/cycle
// FSM (IDLE -> SHIFT -> DONE), results registered and held until consumed.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high, result/zero/illegal_op are stable until that transfer.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal_op,
  output state_e            fsm_state
);

  state_e               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]    work_q, work_d;
  alu_op_e              sh_op_q, sh_op_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;

  alu_op_e              req_op;
  logic [DATA_W-1:0]    comb_y;
  logic                 comb_legal;
  logic                 accept;

  assign req_op = alu_op_e'(alu_op);

  alu_comb u_comb (
    .op    (req_op),
    .a     (op_a),
    .b     (op_b),
    .y     (comb_y),
    .legal (comb_legal)
  );

  // Handshake outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = rst_n && ((state_q == ST_IDLE) ||
                          ((state_q == ST_DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state_q == ST_DONE);
  end

  // Next-state and datapath: shift stepping, hand-off, and request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    sh_op_d   = sh_op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_SHIFT: begin
        work_d = shift_one(sh_op_q, work_q);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d   = ST_DONE;
          result_d  = work_d;
          zero_d    = (work_d == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // accept can only be high in IDLE or in DONE with out_ready.
    if (accept) begin
      if (is_shift(req_op) && (op_b[SHAMT_W-1:0] != '0)) begin
        state_d = ST_SHIFT;
        cnt_d   = op_b[SHAMT_W-1:0];
        work_d  = op_a;
        sh_op_d = req_op;
      end else begin
        state_d = ST_DONE;
        if (is_shift(req_op)) begin
          result_d  = op_a;
          illegal_d = 1'b0;
          zero_d    = (op_a == '0);
        end else begin
          result_d  = comb_y;
          illegal_d = !comb_legal;
          zero_d    = (comb_y == '0);
        end
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      sh_op_q   <= ALU_OR;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      sh_op_q   <= sh_op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, randomized ops
// against a behavioural model, result hold/back-to-back, and reset mid-shift.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  state_e      fsm_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  alu_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Result, illegal flag and edges from acceptance to out_valid.
  task automatic model(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic ill, output int lat);
    int n;
    n   = int'(b % 32);
    ill = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a | b;
      4'b0001: r = a & b;
      4'b0010: r = a + b;
      4'b0011: r = a - b;
      4'b0101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1101: r = (a < b) ? 32'd1 : 32'd0;
      4'b1001: r = a ^ b;
      4'b1000: begin r = a << n;             lat = n + 1; end
      4'b1010: begin r = a >> n;             lat = n + 1; end
      4'b1011: begin r = $signed(a) >>> n;   lat = n + 1; end
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endtask

  // ---------------- driver ----------------
  // Issue one request, then wait for out_valid while scribbling on in_valid.
  // Returns outputs at the first out_valid cycle; does not consume the result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic z, output logic ill, output int lat,
                       output logic ready_in_busy, output logic timeout);
    int guard;
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    step();
    in_valid      = 1'b0;
    lat           = 1;
    ready_in_busy = 1'b0;
    timeout       = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_in_busy = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      alu_op   = 4'($urandom_range(0, 15));
      op_a     = $urandom;
      op_b     = $urandom;
      step();
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) timeout = 1'b1;
    r   = result;
    z   = zero;
    ill = illegal_op;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_total++;
    if ({out_valid, result, zero, illegal_op} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%0b r=%h z=%0b i=%0b want all 0",
               out_valid, result, zero, illegal_op);
    end
    n_total++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %0b want 0", in_ready);
    end
    n_total++;
    if (fsm_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE);
    end
    rst_n = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release_in_ready: got %0b want 1", in_ready);
    end
    step();
  endtask

  task automatic test_directed();
    logic [3:0]  t_op[9]  = '{4'b0010, 4'b0011, 4'b0011, 4'b0101, 4'b1101,
                              4'b1011, 4'b1010, 4'b1000, 4'b1001};
    logic [31:0] t_a[9]   = '{32'd5, 32'h3, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h12345678, 32'hA5A5A5A5};
    logic [31:0] t_b[9]   = '{32'd7, 32'h3, 32'h1, 32'h1, 32'h1,
                              32'd4, 32'd4, 32'h20, 32'hA5A5A5A5};
    logic [31:0] t_r[9]   = '{32'd12, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0,
                              32'hF8000000, 32'h08000000, 32'h12345678, 32'h0};
    int          t_lat[9] = '{1, 1, 1, 1, 1, 5, 5, 1, 1};
    logic [31:0] r;
    logic        z, ill, rdy, to;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i], r, z, ill, lat, rdy, to);
      n_total++;
      if (to !== 1'b0 || lat !== t_lat[i]) begin
        n_bad++;
        $display("FAIL dir%0d_latency: got %0d (timeout=%0b) want %0d", i, lat, to, t_lat[i]);
      end
      n_total++;
      if (r !== t_r[i] || z !== (t_r[i] == 32'd0) || ill !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_result: got r=%h z=%0b i=%0b want r=%h z=%0b i=0",
                 i, r, z, ill, t_r[i], (t_r[i] == 32'd0));
      end
      n_total++;
      if (rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_busy_ready: got in_ready=1 while busy want 0", i);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, r, er;
    logic        z, ill, eill, rdy, to;
    int          lat, elat, errs;
    out_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 8 == 0) a = 32'd0;
      if (i % 5 == 0) b[4:0] = 5'd0;
      model(op, a, b, er, eill, elat);
      exp_q.push_back(er);
      issue(op, a, b, r, z, ill, lat, rdy, to);
      er = exp_q.pop_front();
      n_total++;
      if (to !== 1'b0 || lat !== elat || r !== er || z !== (er == 32'd0) ||
          ill !== eill || rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL rand%0d op=%b a=%h b=%h: got r=%h z=%0b i=%0b lat=%0d want r=%h z=%0b i=%0b lat=%0d",
                 i, op, a, b, r, z, ill, lat, er, (er == 32'd0), eill, elat);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        z, ill, rdy, to;
    int          lat, errs;
    out_ready = 1'b0;
    issue(4'b0010, 32'd100, 32'd23, r, z, ill, lat, rdy, to);
    n_total++;
    if (to !== 1'b0 || r !== 32'd123) begin
      n_bad++;
      $display("FAIL hold_first: got r=%h timeout=%0b want r=0000007b", r, to);
    end
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b1 || result !== 32'd123 || zero !== 1'b0 || in_ready !== 1'b0)
        errs++;
    end
    n_total++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", errs);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 4'b0010;
    op_a      = 32'd7;
    op_b      = 32'd8;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %0b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || result !== 32'd15) begin
      n_bad++;
      $display("FAIL b2b_result: got v=%0b r=%h want v=1 r=0000000f", out_valid, result);
    end
    step();
    issue(4'b0100, 32'hDEADBEEF, 32'h1, r, z, ill, lat, rdy, to);
    n_total++;
    if (to !== 1'b0 || lat !== 1 || r !== 32'd0 || z !== 1'b1 || ill !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_op: got r=%h z=%0b i=%0b lat=%0d want r=0 z=1 i=1 lat=1",
               r, z, ill, lat);
    end
    step();
  endtask

  task automatic test_reset_mid_shift();
    int errs;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 4'b1000;
    op_a      = 32'h0000_0001;
    op_b      = 32'd10;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_total++;
    if (fsm_state !== ST_IDLE || out_valid !== 1'b0 || result !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_shift_reset: got st=%0d v=%0b r=%h want st=0 v=0 r=0",
               fsm_state, out_valid, result);
    end
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid !== 1'b0) errs++;
    end
    n_total++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL stale_result: got out_valid high %0d cycles want 0", errs);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port in_valid, input, 1, operation request present.
REQ-004 SHALL have port in_ready, output, 1, unit accepts a request this cycle.
REQ-005 SHALL have port alu_op, input, 4, ALUOperation code from the ALU control decoder.
REQ-006 SHALL have ports op_a and op_b, input, 32 each; op_a is the first operand; op_b is the second operand (shift amount in op_b[4:0]).
REQ-007 SHALL have port out_valid, output, 1, result registered and held.
REQ-008 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-009 SHALL have port result, output, 32, registered result.
REQ-010 SHALL have port zero, output, 1, registered (result == 0).
REQ-011 SHALL have port illegal_op, output, 1, registered flag: alu_op not in the code table.

Function
REQ-012 SHALL decode alu_op as: 0000 OR, 0001 AND, 0010 ADD, 0011 SUB, 0101 SLT, 1000 SLL, 1001 XOR, 1010 SRL, 1011 SRA, 1101 SLTU; every other code is illegal.
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL assert in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-015 SHALL accept a request when in_valid and in_ready are both high, and SHALL capture alu_op, op_a and op_b.
REQ-016 SHALL, for an accepted non-shift or illegal op, load result, zero and illegal_op at the accepting edge and enter DONE (out_valid high the next cycle, latency 1).
REQ-017 SHALL wrap ADD/SUB modulo 2^32 with no overflow output.
REQ-018 SHALL compute SLT as signed and SLTU as unsigned; the result is 32'h1 or 32'h0.
REQ-019 SHALL set result=0, zero=1 and illegal_op=1 for an illegal op.
REQ-020 SHALL, for an accepted shift with shamt=op_b[4:0]=0, behave as REQ-016 with result=op_a.
REQ-021 SHALL, for an accepted shift with shamt n>0, enter SHIFT, load a 5-bit down-counter with n, and shift the working register by 1 bit per cycle (SLL zero-fill; SRL zero-fill; SRA sign-fill).
REQ-022 SHALL go from SHIFT to DONE on the edge where the counter reaches 0, with out_valid high after exactly n cycles spent in SHIFT.
REQ-023 SHALL keep in_ready low throughout SHIFT and ignore in_valid there.
REQ-024 SHALL, in DONE, hold result, zero, illegal_op and out_valid stable until out_ready is high.
REQ-025 SHALL, in DONE with out_ready high, go to IDLE when no new request is accepted; a simultaneously accepted request SHALL follow REQ-016/020/021 (back-to-back, no bubble for non-shift ops).
REQ-026 SHALL compute zero from the final result only.

Reset
REQ-027 SHALL, when rst_n is low at a rising edge, set state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0 and counter=0, including mid-SHIFT (the in-flight op is discarded).
REQ-028 SHALL drive in_ready low during the cycle rst_n is asserted and high in the first cycle after reset release.

Structure
REQ-029 SHALL place the alu_op code constants (enum alu_op_e) and the FSM state enum in a shared package alu_pkg, which the ALU control decoder also imports.
REQ-030 SHALL put the single-cycle operations (OR/AND/ADD/SUB/SLT/SLTU/XOR) in a combinational sub-module alu_comb; the shift FSM and the handshake stay in alu_exec_unit.

Verification
REQ-031 SHALL cover: ADD, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0.
REQ-032 SHALL cover: SUB, a=b=0x3 -> result=0, zero=1; SUB 0 minus 1 -> 0xFFFFFFFF.
REQ-033 SHALL cover: SLT, a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-034 SHALL cover: SRA, a=0x80000000, b=4 -> 4 cycles in SHIFT with in_ready=0, then result=0xF8000000; SRL with the same operands -> 0x08000000; SLL with shamt=0 -> latency 1, result=a.
REQ-035 SHALL cover: out_ready held low for 3 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with in_valid=1 ADD -> back-to-back accept; alu_op=4'b0100 -> illegal_op=1, result=0.
REQ-036 SHALL cover: rst_n low during the 2nd cycle of SLL by 10 -> next cycle state IDLE, out_valid=0, and no stale result is ever presented.
